// File: rtl/iq_channel_emulator.sv
// I/Q loopback channel emulator: rotate -> gain -> noise+saturate -> delay.
// Channel index 0 carries I, index 1 carries Q throughout the datapath.
module iq_channel_emulator #(
  parameter int          DATA_W    = 12,
  parameter int          DELAY_MAX = 16,
  parameter logic [15:0] SEED_I    = 16'hACE1,
  parameter logic [15:0] SEED_Q    = 16'h1D87,
  localparam int         DLY_W     = $clog2(DELAY_MAX)
) (
  input  logic              clk_32M768,
  input  logic              rst_n_32M768,
  input  logic [DATA_W-1:0] DAC_I,
  input  logic [DATA_W-1:0] DAC_Q,
  input  logic              DAC_valid,
  input  logic [3:0]        GAIN_NUM,
  input  logic [1:0]        ROT_MODE,
  input  logic [3:0]        NOISE_SHIFT,
  input  logic [DLY_W-1:0]  DELAY_CNT,
  output logic [DATA_W-1:0] ADC_I,
  output logic [DATA_W-1:0] ADC_Q,
  output logic              ADC_valid,
  output logic              sat_flag
);

  localparam int STAGES = 3;
  localparam int XW     = DATA_W + 1;  // rotated sample, room for -(-2^(N-1))
  localparam int PW     = DATA_W + 5;  // gain product
  localparam int YW     = DATA_W + 6;  // product plus noise
  localparam logic [15:0]   LFSR_MASK = 16'hB400;
  localparam logic [YW-1:0] SAT_MAX = {{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [YW-1:0] SAT_MIN = {{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] q;
  } smp_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  logic [STAGES:1]         vld_pipe;
  logic [1:0][XW-1:0]      dac_x, rot_x, s1_x;
  logic [1:0][PW-1:0]      prod, s2_p;
  logic [1:0][DATA_W-1:0]  clip_y, s3_y;
  logic [1:0]              clip;
  logic [1:0][15:0]        lfsr;
  logic signed [15:0]      noise [2];
  logic signed [YW-1:0]    y     [2];
  smp_t                    s3, tap;
  smp_t                    dly   [1:DELAY_MAX-1];

  // Sign-extend DAC samples and rotate by quarter turns
  always_comb begin
    dac_x[0] = XW'($signed(DAC_I));
    dac_x[1] = XW'($signed(DAC_Q));
    rot_x    = dac_x;
    unique case (ROT_MODE)
      2'd1:    begin rot_x[0] = -dac_x[1]; rot_x[1] =  dac_x[0]; end
      2'd2:    begin rot_x[0] = -dac_x[0]; rot_x[1] = -dac_x[1]; end
      2'd3:    begin rot_x[0] =  dac_x[1]; rot_x[1] = -dac_x[0]; end
      default: ;
    endcase
  end

  // Gain product, noise injection and clamp to the DATA_W range
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      prod[c]  = $signed(PW'($signed(s1_x[c]))) * $signed(PW'({1'b0, GAIN_NUM}));
      noise[c] = (NOISE_SHIFT == 4'd15) ? 16'sd0 : ($signed(lfsr[c]) >>> NOISE_SHIFT);
      y[c]     = YW'($signed(s2_p[c])) + YW'(noise[c]);
      clip[c]  = 1'b0;
      clip_y[c] = y[c][DATA_W-1:0];
      if (y[c] > $signed(SAT_MAX)) begin
        clip[c]   = 1'b1;
        clip_y[c] = SAT_MAX[DATA_W-1:0];
      end else if (y[c] < $signed(SAT_MIN)) begin
        clip[c]   = 1'b1;
        clip_y[c] = SAT_MIN[DATA_W-1:0];
      end
    end
  end

  // S1..S3 pipeline; invalid slots carry zeros so noise never leaks out
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      vld_pipe <= '0;
      s1_x     <= '0;
      s2_p     <= '0;
      s3_y     <= '0;
      sat_flag <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], DAC_valid};
      s1_x     <= DAC_valid ? rot_x : '0;
      for (int c = 0; c < 2; c++) begin
        s2_p[c] <= $signed(prod[c]) >>> 2;
        s3_y[c] <= vld_pipe[2] ? clip_y[c] : '0;
      end
      if (vld_pipe[2] && (|clip)) sat_flag <= 1'b1;
    end
  end

  // Free-running noise LFSRs, independent per channel
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      lfsr[0] <= SEED_I;
      lfsr[1] <= SEED_Q;
    end else begin
      for (int c = 0; c < 2; c++) lfsr[c] <= lfsr_step(lfsr[c]);
    end
  end

  assign s3  = '{vld: vld_pipe[STAGES], i: s3_y[0], q: s3_y[1]};
  assign tap = (DELAY_CNT == '0) ? s3 : dly[DELAY_CNT];

  // Delay line: entry k holds the S3 slot from k clocks ago
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      for (int k = 1; k < DELAY_MAX; k++) dly[k] <= '0;
    end else begin
      dly[1] <= s3;
      for (int k = 2; k < DELAY_MAX; k++) dly[k] <= dly[k-1];
    end
  end

  // Registered outputs from the selected tap
  always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
    if (!rst_n_32M768) begin
      ADC_valid <= 1'b0;
      ADC_I     <= '0;
      ADC_Q     <= '0;
    end else begin
      ADC_valid <= tap.vld;
      ADC_I     <= tap.i;
      ADC_Q     <= tap.q;
    end
  end

endmodule

// File: tb/tb_iq_channel_emulator.sv
// Directed bench for iq_channel_emulator.
`timescale 1ns/1ps
module tb_iq_channel_emulator;

  localparam int N_NOISE = 4096;

  logic        clk_32M768 = 1'b0;
  logic        rst_n_32M768 = 1'b0;
  logic [11:0] DAC_I = '0, DAC_Q = '0;
  logic        DAC_valid = 1'b0;
  logic [3:0]  GAIN_NUM = 4'd3;
  logic [1:0]  ROT_MODE = 2'd0;
  logic [3:0]  NOISE_SHIFT = 4'd15;
  logic [3:0]  DELAY_CNT = 4'd0;
  logic [11:0] ADC_I, ADC_Q;
  logic        ADC_valid, sat_flag;

  int checks = 0;
  int failures = 0;

  logic [15:0] si [0:N_NOISE+4];
  logic [15:0] sq [0:N_NOISE+4];

  iq_channel_emulator dut (
    .clk_32M768  (clk_32M768),
    .rst_n_32M768(rst_n_32M768),
    .DAC_I       (DAC_I),
    .DAC_Q       (DAC_Q),
    .DAC_valid   (DAC_valid),
    .GAIN_NUM    (GAIN_NUM),
    .ROT_MODE    (ROT_MODE),
    .NOISE_SHIFT (NOISE_SHIFT),
    .DELAY_CNT   (DELAY_CNT),
    .ADC_I       (ADC_I),
    .ADC_Q       (ADC_Q),
    .ADC_valid   (ADC_valid),
    .sat_flag    (sat_flag)
  );

  always #15 clk_32M768 = ~clk_32M768;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  function automatic int noise_of(input logic [15:0] s);
    logic signed [15:0] t;
    t = s;
    return int'(t >>> 11);
  endfunction

  task automatic drive_idle();
    DAC_valid = 1'b0; DAC_I = '0; DAC_Q = '0;
  endtask

  task automatic set_cfg(input logic [3:0] g, input logic [1:0] r,
                         input logic [3:0] ns, input logic [3:0] d);
    GAIN_NUM = g; ROT_MODE = r; NOISE_SHIFT = ns; DELAY_CNT = d;
  endtask

  task automatic flush();
    @(negedge clk_32M768);
    drive_idle();
    repeat (24) @(negedge clk_32M768);
  endtask

  // One-clock DAC pulse; reports clocks until ADC_valid (-1 on timeout)
  task automatic send_one(input logic [11:0] i, input logic [11:0] q, input int max,
                          output int lat, output logic [11:0] oi, output logic [11:0] oq);
    @(negedge clk_32M768);
    DAC_I = i; DAC_Q = q; DAC_valid = 1'b1;
    lat = -1; oi = '0; oq = '0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk_32M768);
      if (n == 1) drive_idle();
      if (ADC_valid === 1'b1) begin
        lat = n; oi = ADC_I; oq = ADC_Q;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    set_cfg(4'd3, 2'd0, 4'd15, 4'd0);
    rst_n_32M768 = 1'b0;
    #70;
    checks++; if (ADC_I !== 12'd0) begin failures++; $display("FAIL reset_adc_i got=%h exp=000", ADC_I); end
    checks++; if (ADC_Q !== 12'd0) begin failures++; $display("FAIL reset_adc_q got=%h exp=000", ADC_Q); end
    checks++; if (ADC_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ADC_valid); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
  endtask

  task automatic test_gain();
    int lat; logic [11:0] oi, oq;
    flush();
    set_cfg(4'd3, 2'd0, 4'd15, 4'd0);
    send_one(12'd800, 12'(-800), 10, lat, oi, oq);
    checks++; if (lat != 4) begin failures++; $display("FAIL gain3_latency got=%0d exp=4", lat); end
    checks++; if (oi !== 12'(600)) begin failures++; $display("FAIL gain3_i got=%0d exp=600", $signed(oi)); end
    checks++; if (oq !== 12'(-600)) begin failures++; $display("FAIL gain3_q got=%0d exp=-600", $signed(oq)); end
    // floor rounding of x*3/4: 1 -> 0, -1 -> -1
    send_one(12'd1, 12'(-1), 10, lat, oi, oq);
    checks++; if (oi !== 12'd0 || oq !== 12'(-1))
      begin failures++; $display("FAIL gain3_floor got=%0d,%0d exp=0,-1", $signed(oi), $signed(oq)); end
    set_cfg(4'd0, 2'd0, 4'd15, 4'd0);
    send_one(12'd800, 12'd5, 10, lat, oi, oq);
    checks++; if (lat != 4 || oi !== 12'd0 || oq !== 12'd0)
      begin failures++; $display("FAIL gain0 got lat=%0d i=%0d q=%0d exp lat=4 i=0 q=0", lat, $signed(oi), $signed(oq)); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL gain_no_sat got=%b exp=0", sat_flag); end
  endtask

  task automatic test_rotate();
    int lat; logic [11:0] oi, oq;
    int exp_i [3] = '{-200, -100, 200};
    int exp_q [3] = '{100, -200, -100};
    flush();
    for (int r = 0; r < 3; r++) begin
      set_cfg(4'd4, 2'(r + 1), 4'd15, 4'd0);
      send_one(12'd100, 12'd200, 10, lat, oi, oq);
      checks++;
      if (lat != 4 || oi !== 12'(exp_i[r]) || oq !== 12'(exp_q[r])) begin
        failures++;
        $display("FAIL rot%0d got lat=%0d i=%0d q=%0d exp lat=4 i=%0d q=%0d",
                 r + 1, lat, $signed(oi), $signed(oq), exp_i[r], exp_q[r]);
      end
    end
  endtask

  task automatic test_delay();
    int lat, extra, dirty; logic [11:0] oi, oq;
    flush();
    set_cfg(4'd4, 2'd0, 4'd15, 4'd8);
    send_one(12'd400, 12'd0, 30, lat, oi, oq);
    checks++; if (lat != 12) begin failures++; $display("FAIL delay8_latency got=%0d exp=12", lat); end
    checks++; if (oi !== 12'd400) begin failures++; $display("FAIL delay8_i got=%0d exp=400", $signed(oi)); end
    extra = 0; dirty = 0;
    repeat (20) begin
      @(negedge clk_32M768);
      if (ADC_valid !== 1'b0) extra++;
      else if (ADC_I !== 12'd0 || ADC_Q !== 12'd0) dirty++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL delay8_single got=%0d extra valids exp=0", extra); end
    checks++; if (dirty != 0) begin failures++; $display("FAIL invalid_zero got=%0d nonzero slots exp=0", dirty); end
  endtask

  task automatic test_saturation();
    int lat; logic [11:0] oi, oq;
    flush();
    set_cfg(4'd15, 2'd0, 4'd15, 4'd0);
    send_one(12'd2047, 12'd0, 10, lat, oi, oq);
    checks++; if (lat != 4 || oi !== 12'd2047)
      begin failures++; $display("FAIL sat_pos got lat=%0d i=%0d exp lat=4 i=2047", lat, $signed(oi)); end
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag_set got=%b exp=1", sat_flag); end
    set_cfg(4'd15, 2'd2, 4'd15, 4'd0);
    send_one(12'h800, 12'd0, 10, lat, oi, oq);
    checks++; if (oi !== 12'd2047 || oq !== 12'd0)
      begin failures++; $display("FAIL sat_neg_rot180 got=%0d,%0d exp=2047,0", $signed(oi), $signed(oq)); end
    set_cfg(4'd15, 2'd0, 4'd15, 4'd0);
    send_one(12'h800, 12'd0, 10, lat, oi, oq);
    checks++; if (oi !== 12'h800) begin failures++; $display("FAIL sat_neg got=%0d exp=-2048", $signed(oi)); end
    flush();
    checks++; if (sat_flag !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b exp=1", sat_flag); end
  endtask

  task automatic test_noise();
    int ei, eq, v, sum, oor, diff, bad;
    si[0] = 16'hACE1; sq[0] = 16'h1D87;
    for (int j = 1; j <= N_NOISE + 4; j++) begin
      si[j] = lfsr_next(si[j-1]);
      sq[j] = lfsr_next(sq[j-1]);
    end
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b0;
    set_cfg(4'd4, 2'd0, 4'd11, 4'd0);
    DAC_I = '0; DAC_Q = '0; DAC_valid = 1'b1;
    #1;
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_cleared got=%b exp=0", sat_flag); end
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    sum = 0; oor = 0; diff = 0; bad = 0;
    for (int k = 1; k <= N_NOISE + 3; k++) begin
      @(negedge clk_32M768);
      if (k == 3) begin
        checks++; if (ADC_valid !== 1'b0) begin failures++; $display("FAIL noise_fill got=%b exp=0", ADC_valid); end
      end
      if (k >= 4) begin
        ei = noise_of(si[k-2]);
        eq = noise_of(sq[k-2]);
        checks++;
        if (ADC_valid !== 1'b1 || ADC_I !== 12'(ei) || ADC_Q !== 12'(eq)) begin
          failures++;
          if (bad < 8) $display("FAIL noise_model k=%0d got v=%b i=%0d q=%0d exp v=1 i=%0d q=%0d",
                                k, ADC_valid, $signed(ADC_I), $signed(ADC_Q), ei, eq);
          bad++;
        end
        v = $signed(ADC_I);
        sum += v;
        if (v < -16 || v > 15) oor++;
        if (ADC_I != ADC_Q) diff++;
      end
    end
    checks++; if (oor != 0) begin failures++; $display("FAIL noise_range got=%0d out of range exp=0", oor); end
    checks++; if (sum >= 2 * N_NOISE || sum <= -2 * N_NOISE)
      begin failures++; $display("FAIL noise_mean got sum=%0d exp |sum|<%0d", sum, 2 * N_NOISE); end
    checks++; if (diff <= N_NOISE / 2)
      begin failures++; $display("FAIL noise_iq_differ got=%0d differing exp>%0d", diff, N_NOISE / 2); end
    drive_idle();
  endtask

  task automatic test_reset_midstream();
    int lat; logic [11:0] oi;
    flush();
    set_cfg(4'd4, 2'd0, 4'd15, 4'd15);
    DAC_I = 12'd100; DAC_Q = 12'(-100); DAC_valid = 1'b1;
    repeat (25) @(negedge clk_32M768);
    checks++; if (ADC_valid !== 1'b1 || ADC_I !== 12'd100)
      begin failures++; $display("FAIL midstream_pre got v=%b i=%0d exp v=1 i=100", ADC_valid, $signed(ADC_I)); end
    #5;
    rst_n_32M768 = 1'b0;
    drive_idle();
    #1;
    checks++; if (ADC_valid !== 1'b0 || ADC_I !== 12'd0 || ADC_Q !== 12'd0)
      begin failures++; $display("FAIL midstream_reset got v=%b i=%0d q=%0d exp 0,0,0", ADC_valid, $signed(ADC_I), $signed(ADC_Q)); end
    @(negedge clk_32M768);
    rst_n_32M768 = 1'b1;
    repeat (3) @(negedge clk_32M768);
    DAC_I = 12'd100; DAC_Q = 12'(-100); DAC_valid = 1'b1;
    lat = -1; oi = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_32M768);
      if (ADC_valid === 1'b1) begin lat = n; oi = ADC_I; break; end
    end
    checks++; if (lat != 19) begin failures++; $display("FAIL midstream_latency got=%0d exp=19", lat); end
    checks++; if (oi !== 12'd100) begin failures++; $display("FAIL midstream_value got=%0d exp=100", $signed(oi)); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_gain();
    test_rotate();
    test_delay();
    test_saturation();
    test_noise();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
